reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_reset_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Staged reset release for a chain of downstream blocks. The external reset
// is asserted asynchronously and deasserted through a short synchronizer.
// After that, the stage resets are released one at a time in ascending order,
// STAGE_CYCLES clocks apart. A soft-reset request in RUN re-asserts every
// stage, holds them for STAGE_CYCLES clocks, and then replays the staged
// release. The end of that replay is marked with a one-cycle ack.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   sw_rst_req  in   soft-reset request, sampled on every rising edge
//   rst_out     out  [NUM_STAGES] active-high reset, bit i drives stage i
//   ready       out  high only while every rst_out bit is low
//   sw_rst_ack  out  one-cycle pulse when a soft-reset sequence completes
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ASSERT   | all stages held in reset, waiting for the synchronized release
//   RELEASE  | stages released one by one, STAGE_CYCLES clocks apart
//   RUN      | all stages out of reset, ready high, soft requests accepted
//   SOFT     | all stages re-asserted, held for STAGE_CYCLES clocks
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_STAGES   = 3,
    parameter int STAGE_CYCLES = 4,
    parameter int SYNC_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  sw_rst_ack
);

    localparam int CNT_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_SOFT    = 2'd3;

    logic [SYNC_DEPTH-1:0] sync_ff;
    logic                  rst_sync;
    logic [1:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;
    logic                  soft_pend;
    logic [NUM_STAGES-1:0] stage_bit;

    // A zero shifts in from the low end. rst_sync therefore falls on the
    // SYNC_DEPTH-th edge after rst drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_ff[SYNC_DEPTH-1];

    // A mask is used rather than a variable bit-select. The mask stays
    // well-formed even when NUM_STAGES is 1.
    assign stage_bit = NUM_STAGES'(1) << idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ASSERT;
            idx        <= '0;
            cnt        <= '0;
            rst_out    <= '1;
            ready      <= 1'b0;
            sw_rst_ack <= 1'b0;
            soft_pend  <= 1'b0;
        end else begin
            sw_rst_ack <= 1'b0;
            case (state)
                ST_ASSERT: begin
                    rst_out <= '1;
                    ready   <= 1'b0;
                    if (!rst_sync) begin
                        state <= ST_RELEASE;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == CNT_LAST) begin
                        rst_out <= rst_out & ~stage_bit;
                        cnt     <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                            idx   <= '0;
                            // Only a release that a soft request started is
                            // acknowledged. A hard reset clears soft_pend.
                            if (soft_pend) begin
                                sw_rst_ack <= 1'b1;
                                soft_pend  <= 1'b0;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req) begin
                        rst_out   <= '1;
                        ready     <= 1'b0;
                        cnt       <= '0;
                        soft_pend <= 1'b1;
                        state     <= ST_SOFT;
                    end
                end
                ST_SOFT: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_RELEASE;
                        idx   <= '0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer. It instantiates two copies:
//   dut   defaults (3 stages, 4 cycles, 2-flop synchronizer)
//   dut1  single stage, 1 cycle
// Edge numbers count rising edges after rst falls. rst always falls between
// edges. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       sw_rst_req1 = 1'b0;
    logic [2:0] rst_out;
    logic       ready;
    logic       sw_rst_ack;
    logic [0:0] rst_out1;
    logic       ready1;
    logic       sw_rst_ack1;

    int n_cmp = 0;
    int n_err = 0;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_STAGES(3), .STAGE_CYCLES(4), .SYNC_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
        .rst_out(rst_out), .ready(ready), .sw_rst_ack(sw_rst_ack)
    );

    reset_sequencer #(.NUM_STAGES(1), .STAGE_CYCLES(1), .SYNC_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req1),
        .rst_out(rst_out1), .ready(ready1), .sw_rst_ack(sw_rst_ack1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hard sequence: stage 0 releases at edge 7, stage 1 at 11, stage 2 at 15.
    function automatic logic [2:0] exp_hard(input int e);
        if (e < 7)  return 3'b111;
        if (e < 11) return 3'b110;
        if (e < 15) return 3'b100;
        return 3'b000;
    endfunction

    // Soft sequence, counted from the request edge E: 4 hold cycles, then
    // releases at E+8, E+12 and E+16.
    function automatic logic [2:0] exp_soft(input int k);
        if (k < 8)  return 3'b111;
        if (k < 12) return 3'b110;
        if (k < 16) return 3'b100;
        return 3'b000;
    endfunction

    task automatic hard_seq(input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk); #1;
            chk($sformatf("hard_rst_out_e%0d", e), rst_out, exp_hard(e));
            chk($sformatf("hard_ready_e%0d", e), ready, (e >= 15));
            chk($sformatf("hard_ack_e%0d", e), sw_rst_ack, 0);
            chk($sformatf("ns1_rst_out_e%0d", e), rst_out1, (e < 4));
            chk($sformatf("ns1_ready_e%0d", e), ready1, (e >= 4));
        end
    endtask

    task automatic soft_seq();
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            chk($sformatf("soft_rst_out_k%0d", k), rst_out, exp_soft(k));
            chk($sformatf("soft_ready_k%0d", k), ready, (k >= 16));
            chk($sformatf("soft_ack_k%0d", k), sw_rst_ack, (k == 16));
        end
    endtask

    // Call this task 1 time unit after a rising edge. rst pulses and falls
    // before the next edge.
    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        chk("async_rst_out", rst_out, 3'b111);
        chk("async_ready", ready, 0);
        chk("async_ack", sw_rst_ack, 0);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("inv_ready_implies_clear", ready && (rst_out != 3'b000), 0);
        chk("inv_release_order", |(~rst_out & {rst_out[1:0], 1'b0}), 0);
        chk("inv_ack_single", prev_ack && sw_rst_ack, 0);
        prev_ack = sw_rst_ack;
    end

    initial begin
        // Reset state while rst is held.
        #12;
        chk("reset_rst_out", rst_out, 3'b111);
        chk("reset_ready", ready, 0);
        chk("reset_ack", sw_rst_ack, 0);
        chk("reset_ns1_rst_out", rst_out1, 1);

        // Defaults and the single-stage copy, released between edges.
        @(negedge clk);
        rst = 1'b0;
        hard_seq(16);

        // Soft pulse in RUN.
        sw_rst_req = 1'b1;
        @(posedge clk); #1;
        sw_rst_req = 1'b0;
        chk("soft_E_rst_out", rst_out, 3'b111);
        chk("soft_E_ready", ready, 0);
        soft_seq();
        @(posedge clk); #1;
        chk("soft_ack_clear", sw_rst_ack, 0);
        chk("soft_run_hold", rst_out, 3'b000);

        // Hard reset from RUN, then again after stage 0 has released.
        pulse_rst();
        hard_seq(8);
        pulse_rst();
        hard_seq(16);

        // Hard reset during SOFT aborts the sequence. No ack may follow.
        sw_rst_req = 1'b1;
        @(posedge clk); #1;
        sw_rst_req = 1'b0;
        @(posedge clk); #1;
        chk("mid_soft_rst_out", rst_out, 3'b111);
        pulse_rst();
        hard_seq(16);

        // rst and sw_rst_req asserted together. rst wins.
        sw_rst_req = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_vs_sw_rst_out", rst_out, 3'b111);
        chk("rst_vs_sw_ack", sw_rst_ack, 0);
        sw_rst_req = 1'b0;
        #2 rst = 1'b0;
        hard_seq(16);

        // Request held through the hard release. It takes effect at edge 16,
        // then retriggers right after the soft sequence returns to RUN.
        pulse_rst();
        sw_rst_req = 1'b1;
        hard_seq(15);
        @(posedge clk); #1;
        chk("held_e16_rst_out", rst_out, 3'b111);
        chk("held_e16_ready", ready, 0);
        soft_seq();
        @(posedge clk); #1;
        chk("retrigger_rst_out", rst_out, 3'b111);
        chk("retrigger_ready", ready, 0);
        chk("retrigger_ack", sw_rst_ack, 0);
        sw_rst_req = 1'b0;
        soft_seq();

        // Random rst and sw_rst_req. The negedge monitor checks the invariants.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            sw_rst_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        sw_rst_req = 1'b0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
